// File: rtl/maxpool_stage.sv
// Streaming 2x2 signed max-pooling stage: pairs columns in a hold register, keeps
// a half-row line buffer of pair maxima and emits one pooled maximum per window.
module maxpool_stage #(
    parameter int DW   = 16,
    parameter int COLS = 8,
    parameter int ROWS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 inValid,
    input  logic signed [DW-1:0] inData,
    output logic                 inReady,
    output logic                 outValid,
    output logic signed [DW-1:0] outData,
    output logic                 done
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int HN = COLS / 2;
    localparam int HW = (HN > 1) ? $clog2(HN) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic signed [DW-1:0] hold;
    logic signed [DW-1:0] lbuf [HN];
    logic signed [DW-1:0] pm;
    logic [HW-1:0]        lidx;
    logic                 acc;
    logic                 last;

    function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
        return (a >= b) ? a : b;
    endfunction

    assign acc  = inValid & inReady;
    assign last = (row == ROW_LAST) && (col == COL_LAST);
    assign lidx = HW'(col >> 1);
    assign pm   = smax(hold, inData);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (acc && last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control: state, registered state decodes and frame position counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            inReady <= 1'b0;
            done    <= 1'b0;
            col     <= '0;
            row     <= '0;
        end else begin
            state   <= state_nxt;
            inReady <= (state_nxt == RUN);
            done    <= (state_nxt == DONE);
            if (state == IDLE && start) begin
                col <= '0;
                row <= '0;
            end else if (acc) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Output stage: bottom-right sample of a window completes the 2x2 maximum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold     <= '0;
            outValid <= 1'b0;
            outData  <= '0;
        end else begin
            outValid <= acc & row[0] & col[0];
            if (acc && !col[0])
                hold <= inData;
            if (acc && row[0] && col[0])
                outData <= smax(lbuf[lidx], pm);
        end
    end

    // Every entry is rewritten on an even row before its odd-row read, so no reset.
    always_ff @(posedge clk) begin
        if (acc && !row[0] && col[0])
            lbuf[lidx] <= pm;
    end

endmodule

// File: tb/tb_maxpool_stage.sv
// Randomised and directed bench for maxpool_stage; a 4x4 and a default 8x8
// instance are checked against a window-maximum reference model.
module tb_maxpool_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                start4, vld4, rdy4, ov4, dn4;
    logic signed [15:0]  data4, od4;
    logic                start8, vld8, rdy8, ov8, dn8;
    logic signed [15:0]  data8, od8;

    maxpool_stage #(.DW(16), .COLS(4), .ROWS(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .inValid(vld4), .inData(data4),
        .inReady(rdy4), .outValid(ov4), .outData(od4), .done(dn4)
    );

    maxpool_stage u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .inValid(vld8), .inData(data8),
        .inReady(rdy8), .outValid(ov8), .outData(od8), .done(dn8)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int obs4[$];
    int obs8[$];
    int dcnt4 = 0;
    int dcnt8 = 0;
    bit acc4_q = 1'b0;
    bit acc8_q = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: maximum of each 2x2 window of a row-major frame.
    task automatic pool_ref(input int d[$], input int c, input int r, output int e[$]);
        int q[$];
        int m;
        for (int r2 = 0; r2 < r / 2; r2++)
            for (int c2 = 0; c2 < c / 2; c2++) begin
                m = d[2 * r2 * c + 2 * c2];
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        if (d[(2 * r2 + dr) * c + 2 * c2 + dc] > m)
                            m = d[(2 * r2 + dr) * c + 2 * c2 + dc];
                q.push_back(m);
            end
        e = q;
    endtask

    always @(posedge clk) begin
        acc4_q = vld4 && rdy4;
        acc8_q = vld8 && rdy8;
    end

    always @(negedge clk) begin
        if (ov4) begin
            obs4.push_back(int'(od4));
            chk("strobe_lat4", int'(acc4_q), 1);
        end
        if (dn4) begin
            dcnt4++;
            chk("done_strobe4", int'(ov4), 1);
        end
        if (ov8) begin
            obs8.push_back(int'(od8));
            chk("strobe_lat8", int'(acc8_q), 1);
        end
        if (dn8) begin
            dcnt8++;
            chk("done_strobe8", int'(ov8), 1);
        end
    end

    task automatic drive4(input int d[$], input bit stall, input bit midstart, input bit idlevld);
        if (idlevld) begin
            @(negedge clk);
            vld4  = 1'b1;
            data4 = 16'sd999;
            repeat (3) begin
                @(negedge clk);
                chk("idle_rdy4", int'(rdy4), 0);
            end
            vld4 = 1'b0;
        end
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        chk("rdy_rise4", int'(rdy4), 1);
        for (int i = 0; i < d.size(); i++) begin
            vld4   = 1'b1;
            data4  = 16'(d[i]);
            start4 = midstart && (i == 6);
            @(negedge clk);
            start4 = 1'b0;
            if (stall && i != d.size() - 1) begin
                vld4 = 1'b0;
                repeat (2) @(negedge clk);
            end
        end
        vld4 = 1'b0;
        chk("rdy_fall4", int'(rdy4), 0);
    endtask

    task automatic drive8(input int d[$]);
        @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        chk("rdy_rise8", int'(rdy8), 1);
        for (int i = 0; i < d.size(); i++) begin
            vld8  = 1'b1;
            data8 = 16'(d[i]);
            @(negedge clk);
            if ($urandom_range(0, 3) == 0 && i != d.size() - 1) begin
                vld8  = 1'b0;
                data8 = 16'($urandom);
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        vld8 = 1'b0;
        chk("rdy_fall8", int'(rdy8), 0);
    endtask

    task automatic check_frame(input bit big, input int exp[$], input int ndone, input string tag);
        int got[$];
        int nd;
        repeat (4) @(negedge clk);
        if (big) begin
            got = obs8;
            nd  = dcnt8;
        end else begin
            got = obs4;
            nd  = dcnt4;
        end
        chk({tag, "_cnt"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk({tag, "_val"}, (i < got.size()) ? got[i] : -999999, exp[i]);
        chk({tag, "_done"}, nd, ndone);
        obs4.delete();
        obs8.delete();
        dcnt4 = 0;
        dcnt8 = 0;
    endtask

    initial begin
        int lin[$], neg[$], mix[$], hi[$], rnd[$], e[$], e2[$];
        rst = 1'b0;
        start4 = 1'b0; vld4 = 1'b0; data4 = '0;
        start8 = 1'b0; vld8 = 1'b0; data8 = '0;
        repeat (3) @(negedge clk);
        chk("rst_rdy4", int'(rdy4), 0);
        chk("rst_ov4", int'(ov4), 0);
        chk("rst_od4", int'(od4), 0);
        chk("rst_dn4", int'(dn4), 0);
        chk("rst_rdy8", int'(rdy8), 0);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            lin.push_back(i);
            neg.push_back(-1 - i);
            hi.push_back(i + 100);
            mix.push_back((i % 4 == 1) ? 1 : ((i % 4 == 3) ? -1 : -32768));
        end

        drive4(lin, 1'b0, 1'b0, 1'b0);
        pool_ref(lin, 4, 4, e);
        check_frame(1'b0, e, 1, "lin");

        drive4(neg, 1'b0, 1'b0, 1'b0);
        pool_ref(neg, 4, 4, e);
        check_frame(1'b0, e, 1, "neg");

        drive4(mix, 1'b0, 1'b0, 1'b0);
        pool_ref(mix, 4, 4, e);
        check_frame(1'b0, e, 1, "mix");

        drive4(lin, 1'b1, 1'b0, 1'b0);
        pool_ref(lin, 4, 4, e);
        check_frame(1'b0, e, 1, "stall");

        drive4(lin, 1'b0, 1'b1, 1'b1);
        pool_ref(lin, 4, 4, e);
        check_frame(1'b0, e, 1, "disturb");

        // Reset after six accepted samples: one strobe (5) has already left.
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vld4  = 1'b1;
            data4 = 16'(i);
            @(negedge clk);
        end
        vld4 = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_rdy", int'(rdy4), 0);
        chk("mid_rst_ov", int'(ov4), 0);
        chk("mid_rst_od", int'(od4), 0);
        chk("mid_rst_dn", int'(dn4), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_idle", int'(rdy4), 0);
        obs4.delete();
        dcnt4 = 0;
        drive4(lin, 1'b0, 1'b0, 1'b0);
        pool_ref(lin, 4, 4, e);
        check_frame(1'b0, e, 1, "after_rst");

        drive4(lin, 1'b0, 1'b0, 1'b0);
        drive4(hi, 1'b0, 1'b0, 1'b0);
        pool_ref(lin, 4, 4, e);
        pool_ref(hi, 4, 4, e2);
        e = {e, e2};
        check_frame(1'b0, e, 2, "b2b");

        for (int f = 0; f < 2; f++) begin
            rnd.delete();
            for (int i = 0; i < 64; i++)
                rnd.push_back(int'($signed(16'($urandom))));
            rnd[3] = -32768;
            rnd[11] = -1;
            drive8(rnd);
            pool_ref(rnd, 8, 8, e);
            check_frame(1'b1, e, 1, "rand8");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
